// File: rtl/apb_arb_pkg.sv
// rtl/apb_arb_pkg.sv - shared types, defaults and round-robin pick function for the APB master arbiter
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_TIMEOUT = 16;
  localparam int MAX_REQ     = 8;
  localparam int MAX_IDW     = 3;

  // First requester after 'last' (mod n) with valid set; returns 'last' when none is valid.
  function automatic logic [MAX_IDW-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                 input logic [MAX_IDW-1:0] last,
                                                 input int n);
    logic [MAX_IDW-1:0] pick;
    int idx;
    pick = last;
    for (int k = MAX_REQ; k >= 1; k--) begin
      idx = (int'(last) + k) % n;
      if (k <= n && valid[idx[MAX_IDW-1:0]]) pick = idx[MAX_IDW-1:0];
    end
    return pick;
  endfunction

endpackage

// File: rtl/apb_rr_arbiter.sv
// rtl/apb_rr_arbiter.sv - combinational round-robin winner with a registered last-grant pointer
module apb_rr_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic                       PCLK,
  input  logic                       PRESET,
  input  logic [NUM_REQ-1:0]         valid,
  input  logic                       update,
  output logic [$clog2(NUM_REQ)-1:0] winner,
  output logic                       any_valid
);

  localparam int IDW = $clog2(NUM_REQ);

  logic [IDW-1:0]     last_grant;
  logic [MAX_REQ-1:0] valid_ext;

  always_comb begin
    valid_ext                = '0;
    valid_ext[NUM_REQ-1:0]   = valid;
  end

  assign any_valid = |valid;
  assign winner    = IDW'(rr_pick(valid_ext, MAX_IDW'(last_grant), NUM_REQ));

  // Starting at NUM_REQ-1 makes requester 0 the first winner after reset.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      last_grant <= IDW'(NUM_REQ - 1);
    end else if (update) begin
      last_grant <= winner;
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// rtl/apb_master_arbiter.sv - APB master sharing one bus between NUM_REQ requesters with wait-state timeout
module apb_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                        PCLK,
  input  logic                        PRESET,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0]          req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0]  rsp_id,
  output logic [DATA_W-1:0]           rsp_rdata,
  output logic                        rsp_err,
  output logic                        rsp_timeout,
  output logic                        PSEL,
  output logic                        PENABLE,
  output logic                        PWRITE,
  output logic [ADDR_W-1:0]           PADDR,
  output logic [DATA_W-1:0]           PWDATA,
  output logic                        transfer,
  input  logic [DATA_W-1:0]           PRDATA,
  input  logic                        PREADY,
  input  logic                        PSLVERR
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(TIMEOUT);

  apb_state_e     state_q, state_d;
  logic [CW-1:0]  wait_cnt;
  logic [IDW-1:0] id_q, winner;
  logic           any_valid, timeout_hit, done, grant;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_write;

  apb_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .valid     (req_valid),
    .update    (grant),
    .winner    (winner),
    .any_valid (any_valid)
  );

  // A timeout ends the transfer exactly like PREADY would, so both feed 'done'.
  assign timeout_hit = (state_q == ACCESS) && !PREADY && (wait_cnt == CW'(TIMEOUT - 1));
  assign done        = (state_q == ACCESS) && (PREADY || timeout_hit);
  assign grant       = ((state_q == IDLE) || done) && any_valid;
  assign transfer    = done && any_valid;
  assign req_ready   = grant ? (NUM_REQ'(1) << winner) : '0;
  assign PSEL        = (state_q != IDLE);
  assign PENABLE     = (state_q == ACCESS);

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_write = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == IDW'(i)) begin
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
        sel_write = req_write[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (done) state_d = any_valid ? SETUP : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q  <= IDLE;
      wait_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        wait_cnt <= '0;
      end else if ((state_q == ACCESS) && !PREADY && !timeout_hit) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

  // Bus controls only move on acceptance edges, keeping them stable through the transfer.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      PADDR  <= '0;
      PWDATA <= '0;
      PWRITE <= 1'b0;
      id_q   <= '0;
    end else if (grant) begin
      PADDR  <= sel_addr;
      PWDATA <= sel_wdata;
      PWRITE <= sel_write;
      id_q   <= winner;
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      rsp_valid <= done;
      if (done) begin
        rsp_id      <= id_q;
        rsp_rdata   <= (!PWRITE && !timeout_hit) ? PRDATA : '0;
        rsp_err     <= (PREADY && PSLVERR) || timeout_hit;
        rsp_timeout <= timeout_hit;
      end else begin
        rsp_id      <= '0;
        rsp_rdata   <= '0;
        rsp_err     <= 1'b0;
        rsp_timeout <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb/tb_apb_master_arbiter.sv - self-checking bench for apb_master_arbiter
module tb_apb_master_arbiter;

  localparam int N   = 4;
  localparam int AW  = 8;
  localparam int DW  = 8;
  localparam int TO  = 16;
  localparam int IDW = $clog2(N);

  logic            PCLK = 1'b0;
  logic            PRESET;
  logic [N-1:0]    req_valid, req_write, req_ready;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic            rsp_valid, rsp_err, rsp_timeout;
  logic [IDW-1:0]  rsp_id;
  logic [DW-1:0]   rsp_rdata, PWDATA, PRDATA;
  logic [AW-1:0]   PADDR;
  logic            PSEL, PENABLE, PWRITE, transfer, PREADY, PSLVERR;

  apb_master_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .transfer(transfer), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  int checks = 0;
  int errors = 0;

  // Reference model: transfer in flight, its phase, and the count of PREADY-low ACCESS cycles.
  bit            m_busy, m_setup, m_write, m_rv, m_rerr, m_rto;
  int            m_waits, m_last, m_id, m_rid;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;

  logic [N-1:0]   seen_ready;
  bit             got_rsp;
  int             sel_cnt;
  logic [IDW-1:0] c_id;
  logic [DW-1:0]  c_rdata;
  logic           c_err, c_to;

  typedef struct {
    logic [N-1:0]  mask;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] prdata;
    int            waits;
    logic          slverr;
    int            exp_id;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
    logic          exp_to;
    int            exp_sel;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_setup = 0; m_rv = 0; m_waits = 0; m_last = N - 1;
  endtask

  // Called at a negedge with inputs already driven; checks, advances the model, returns at next negedge.
  task automatic tick();
    bit done, tmo, acc;
    int g, idx;
    logic [N-1:0] exp_ready;
    #1;
    tmo  = m_busy && !m_setup && !PREADY && (m_waits == TO - 1);
    done = m_busy && !m_setup && (PREADY || tmo);
    acc  = !m_busy || done;
    g = -1;
    if (acc) begin
      for (int k = 1; k <= N; k++) begin
        idx = (m_last + k) % N;
        if (g < 0 && req_valid[idx]) g = idx;
      end
    end
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    check("psel", 32'(PSEL), 32'(m_busy));
    check("penable", 32'(PENABLE), 32'(m_busy && !m_setup));
    check("transfer", 32'(transfer), 32'(done && (req_valid != '0)));
    if (m_busy) begin
      check("paddr", 32'(PADDR), 32'(m_addr));
      check("pwdata", 32'(PWDATA), 32'(m_wdata));
      check("pwrite", 32'(PWRITE), 32'(m_write));
    end
    check("rsp_valid", 32'(rsp_valid), 32'(m_rv));
    if (m_rv) begin
      check("rsp_id", 32'(rsp_id), 32'(m_rid));
      check("rsp_rdata", 32'(rsp_rdata), 32'(m_rdata));
      check("rsp_err", 32'(rsp_err), 32'(m_rerr));
      check("rsp_timeout", 32'(rsp_timeout), 32'(m_rto));
    end
    seen_ready = req_ready;
    if (PSEL) sel_cnt++;
    if (rsp_valid) begin
      got_rsp = 1; c_id = rsp_id; c_rdata = rsp_rdata; c_err = rsp_err; c_to = rsp_timeout;
    end
    m_rv = done;
    if (done) begin
      m_rid   = m_id;
      m_rdata = (!m_write && !tmo) ? PRDATA : '0;
      m_rerr  = tmo || PSLVERR;
      m_rto   = tmo;
      m_busy  = 0;
    end else if (m_busy && !m_setup) begin
      m_waits++;
    end
    m_setup = 0;
    if (g >= 0) begin
      m_busy = 1; m_setup = 1; m_waits = 0; m_last = g; m_id = g;
      m_addr  = req_addr[g*AW +: AW];
      m_wdata = req_wdata[g*DW +: DW];
      m_write = req_write[g];
    end
    @(negedge PCLK);
  endtask

  task automatic apply_reset();
    PRESET = 1'b1; req_valid = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    #1;
    check("rst_psel", 32'(PSEL), 32'd0);
    check("rst_penable", 32'(PENABLE), 32'd0);
    check("rst_pwrite", 32'(PWRITE), 32'd0);
    check("rst_paddr", 32'(PADDR), 32'd0);
    check("rst_pwdata", 32'(PWDATA), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_transfer", 32'(transfer), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    @(negedge PCLK);
    PRESET = 1'b0;
    model_reset();
  endtask

  task automatic run_vec(input int vi);
    vec_t v;
    bit in_acc;
    int acc_cnt;
    v = vecs[vi];
    acc_cnt = 0; got_rsp = 0; sel_cnt = 0;
    req_valid = v.mask; req_write = {N{v.wr}};
    req_addr = {N{v.addr}}; req_wdata = {N{v.wdata}}; PRDATA = v.prdata;
    for (int c = 0; c < 40 && !got_rsp; c++) begin
      in_acc  = m_busy && !m_setup;
      PREADY  = in_acc && (acc_cnt >= v.waits);
      PSLVERR = PREADY ? v.slverr : 1'b1;
      tick();
      if (in_acc) acc_cnt++;
      if (seen_ready != '0) req_valid = '0;
    end
    PREADY = 1'b0; PSLVERR = 1'b0;
    tick();
    check($sformatf("v%0d_got_rsp", vi), 32'(got_rsp), 32'd1);
    check($sformatf("v%0d_id", vi), 32'(c_id), 32'(v.exp_id));
    check($sformatf("v%0d_rdata", vi), 32'(c_rdata), 32'(v.exp_rdata));
    check($sformatf("v%0d_err", vi), 32'(c_err), 32'(v.exp_err));
    check($sformatf("v%0d_timeout", vi), 32'(c_to), 32'(v.exp_to));
    check($sformatf("v%0d_psel_cycles", vi), 32'(sel_cnt), 32'(v.exp_sel));
  endtask

  initial begin
    int order[$];
    int exp_order[5];
    int hang;

    vecs[0] = '{4'b0001, 1'b0, 8'h10, 8'h00, 8'hA5, 0,  1'b0, 0, 8'hA5, 1'b0, 1'b0, 2};
    vecs[1] = '{4'b0010, 1'b1, 8'h22, 8'h5C, 8'h77, 3,  1'b0, 1, 8'h00, 1'b0, 1'b0, 5};
    vecs[2] = '{4'b0100, 1'b1, 8'h3A, 8'hC3, 8'h11, 0,  1'b1, 2, 8'h00, 1'b1, 1'b0, 2};
    vecs[3] = '{4'b1000, 1'b0, 8'h44, 8'h00, 8'h99, 99, 1'b0, 3, 8'h00, 1'b1, 1'b1, 17};
    vecs[4] = '{4'b0001, 1'b0, 8'h5F, 8'h00, 8'h3C, 1,  1'b1, 0, 8'h3C, 1'b1, 1'b0, 3};

    PRESET = 1'b1; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    model_reset();
    @(negedge PCLK);
    apply_reset();

    for (int i = 0; i < 5; i++) run_vec(i);

    apply_reset();
    req_valid = '1; req_write = 4'b1010; PREADY = 1'b1; PSLVERR = 1'b0; PRDATA = 8'h6E;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW]  = AW'(8'h80 + i);
      req_wdata[i*DW +: DW] = DW'(8'hF0 + i);
    end
    for (int c = 0; c < 10; c++) begin
      tick();
      for (int i = 0; i < N; i++) if (seen_ready[i]) order.push_back(i);
    end
    exp_order = '{0, 1, 2, 3, 0};
    check("rr_grant_count", 32'(order.size()), 32'd5);
    if (order.size() >= 5)
      for (int i = 0; i < 5; i++) check($sformatf("rr_order%0d", i), 32'(order[i]), 32'(exp_order[i]));

    apply_reset();
    req_valid = 4'b0100; PREADY = 1'b0;
    tick();
    req_valid = '0;
    repeat (4) tick();
    #2;
    apply_reset();
    repeat (2) tick();
    req_valid = '1;
    tick();
    check("post_reset_grant", 32'(seen_ready), 32'd1);

    apply_reset();
    hang = 0;
    for (int c = 0; c < 1500; c++) begin
      if (hang == 0 && $urandom_range(0, 60) == 0) hang = 20;
      req_valid = N'($urandom_range(0, (1 << N) - 1));
      req_write = N'($urandom_range(0, (1 << N) - 1));
      req_addr  = $urandom;
      req_wdata = $urandom;
      PRDATA    = DW'($urandom_range(0, 255));
      PREADY    = (hang > 0) ? 1'b0 : ($urandom_range(0, 2) != 0);
      PSLVERR   = ($urandom_range(0, 3) == 0);
      if (hang > 0) hang--;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_master_arbiter.md
Name: apb_master_arbiter

Overview:
- APB master that shares a single APB bus between NUM_REQ local requesters.
- Round-robin arbitration; sequences the IDLE -> SETUP -> ACCESS protocol; supports back-to-back transfers.
- Bounds slave wait states with a timeout counter.
- Sits between requester blocks and the APB slave/bus that APB_assertions monitors; drives PSEL/PENABLE/PADDR/PWDATA/PWRITE/transfer.

Parameters:
- NUM_REQ, 4, number of requesters, 2..8.
- ADDR_W, 8, PADDR width.
- DATA_W, 8, PWDATA/PRDATA width.
- TIMEOUT, 16, maximum ACCESS cycles with PREADY low before forced termination, >=2.

Ports:
- PCLK  in  1  clock; all logic on posedge.
- PRESET  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request pending; held until accepted.
- req_write  in  NUM_REQ  per-requester: 1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i uses slice [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  packed write data, sliced the same way.
- req_ready  out  NUM_REQ  one-hot, combinational; request accepted this cycle.
- rsp_valid  out  1  one-cycle pulse; transfer finished.
- rsp_id  out  $clog2(NUM_REQ)  requester index of the finished transfer.
- rsp_rdata  out  DATA_W  PRDATA for reads; 0 for writes and timeouts.
- rsp_err  out  1  PSLVERR, or timeout.
- rsp_timeout  out  1  termination was caused by timeout.
- PSEL, PENABLE, PWRITE  out  1 each  APB master controls.
- PADDR  out  ADDR_W  APB address.
- PWDATA  out  DATA_W  APB write data.
- transfer  out  1  another transfer starts immediately after the current one.
- PRDATA  in  DATA_W  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB slave error.

Behaviour:
- Reset (async, PRESET=1):
  - State = IDLE.
  - All outputs 0; PADDR/PWDATA 0.
  - Round-robin pointer last_grant = NUM_REQ-1, so requester 0 wins first.
  - Timeout counter 0.
- FSM states and transitions:
  - IDLE: PSEL=0, PENABLE=0. If any req_valid, accept winner g and go to SETUP next cycle.
  - SETUP: PSEL=1, PENABLE=0. Always go to ACCESS next cycle.
  - ACCESS: PSEL=1, PENABLE=1.
    - PREADY=1 completes the transfer.
    - Otherwise the counter increments.
    - If the counter reaches TIMEOUT-1 while PREADY=0, terminate with a timeout.
- Acceptance points: the cycle in IDLE, or the completion/timeout cycle in ACCESS.
  - At an acceptance point, req_ready[g]=1 for the round-robin winner: first index after last_grant, modulo NUM_REQ, with req_valid set.
  - On that clock edge, latch PADDR/PWDATA/PWRITE from slice g, latch the granted id, and set last_grant=g.
  - req_ready is 0 in SETUP and in ACCESS wait cycles.
- Back-to-back: if a request is accepted in the completion cycle, the next state is SETUP.
  - PSEL stays 1 and PENABLE falls to 0.
  - transfer is combinational: 1 in ACCESS when (PREADY or timeout) and any req_valid; else 0.
  - With no pending request, the next state is IDLE and PSEL falls.
- Stability: PADDR/PWDATA/PWRITE/PSEL are held constant from SETUP through the completion cycle. They change only on acceptance edges.
- Response: registered, asserted the cycle after completion.
  - rsp_valid=1 for exactly one cycle per transfer; no backpressure.
  - rsp_id = latched id.
  - rsp_rdata = PRDATA if read and not timeout, else 0.
  - rsp_err = PSLVERR or timeout.
  - rsp_timeout = timeout.
- Timeout termination: treated as completion.
  - PSEL/PENABLE drop, or re-SETUP for the next request.
  - The counter clears at every SETUP entry.
- PSLVERR is sampled only in the completion cycle (ACCESS and PREADY); it is ignored elsewhere.
- Requests are accepted only when req_valid is high; dropping req_valid before acceptance withdraws the request without side effects.
- Reset mid-transfer: immediate return to IDLE with all outputs 0. No response is issued for the aborted transfer.
- Minimum transfer: 2 cycles (SETUP plus one ACCESS with PREADY=1). Throughput is 1 transfer per 2 cycles under continuous requests.

Decomposition:
- Package apb_arb_pkg:
  - typedef enum {IDLE, SETUP, ACCESS} apb_state_e.
  - Default width localparams.
  - Function rr_pick(valid, last) returning the winner index.
- One sub-module, apb_rr_arbiter: combinational round-robin winner plus registered last_grant pointer, with an update enable.
- FSM, latching, timeout counter and response register stay in the top level.

Test Plan:
- Single read: req_valid=4'b0001, addr 8'h10; slave PREADY=1 on the first ACCESS cycle, PRDATA=8'hA5.
  -> PSEL high 2 cycles, PENABLE in cycle 2; rsp_valid with id=0, rdata=8'hA5, err=0.
- Round-robin: req_valid=4'b1111 held, zero-wait slave.
  -> grant order 0,1,2,3,0; PSEL continuously high; transfer=1 on each completion; PENABLE toggles 0/1.
- Wait states: write addr 8'h22, data 8'h5C; PREADY low 3 ACCESS cycles, then high.
  -> PADDR/PWDATA/PWRITE stable for all 5 cycles; rsp_valid one cycle after PREADY.
- Slave error: PSLVERR=1 with PREADY on a write from requester 2.
  -> rsp_err=1, rsp_timeout=0, rsp_id=2, rsp_rdata=0.
- Timeout: PREADY held 0, TIMEOUT=16.
  -> termination after 16 ACCESS cycles; rsp_err=1, rsp_timeout=1; PSEL drops if no request pending.
- Reset mid-ACCESS: assert PRESET during ACCESS wait.
  -> PSEL/PENABLE/rsp_valid 0 asynchronously; next grant goes to requester 0.
